// File: rtl/btn_debouncer_pkg.sv
// Shared Simon button constants: button count, colour indices and arbitration states.
// Pure declarations; no timing or flow control of its own.
package btn_debouncer_pkg;

    localparam int NUM_BTNS = 4;

    localparam logic [1:0] COLOUR_0 = 2'd0;
    localparam logic [1:0] COLOUR_1 = 2'd1;
    localparam logic [1:0] COLOUR_2 = 2'd2;
    localparam logic [1:0] COLOUR_3 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_LOCKOUT = 2'd2
    } arb_state_e;

    // Scans high to low so the lowest set index is the one left standing.
    function automatic logic [1:0] lowest_set(input logic [NUM_BTNS-1:0] v);
        logic [1:0] idx;
        idx = COLOUR_0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[1:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One button: 2-flop synchroniser plus stability counter producing a debounced level.
// db follows raw DEBOUNCE_CYCLES+2 edges after the first sample; no backpressure.
module btn_debounce_bit
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count only advances while the synchronised input disagrees with db, so it never passes CNT_MAX.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/btn_debouncer.sv
// Debounces four raw buttons and arbitrates them to a single accepted press with pulses.
// Outputs lag a stable raw change by DEBOUNCE_CYCLES+3 edges; no backpressure.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] btns,
    output logic [1:0]          num,
    output logic                pressed,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic [NUM_BTNS-1:0] db_btns
);

    logic [NUM_BTNS-1:0] db;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_bit
        btn_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_bit (
            .clk  (clk),
            .reset(reset),
            .raw  (btns[g]),
            .db   (db[g])
        );
    end

    arb_state_e state_q;
    arb_state_e state_d;
    logic [1:0] num_q;
    logic [1:0] num_d;
    logic       pressed_q;
    logic       pressed_d;
    logic       press_q;
    logic       press_d;
    logic       release_q;
    logic       release_d;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                pressed_d = 1'b0;
                if (db != '0) begin
                    num_d     = lowest_set(db);
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    state_d   = ST_HELD;
                end
            end
            ST_HELD: begin
                pressed_d = 1'b1;
                if (!db[num_q]) begin
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                    // Anything still held from a chord must be let go before it can win.
                    state_d   = (db == '0) ? ST_IDLE : ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                pressed_d = 1'b0;
                if (db == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                pressed_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            num_q     <= COLOUR_0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign num           = num_q;
    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign db_btns       = db;

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer with a 4-sample debounce: directed timing, a vector table and random stimulus.
module tb_btn_debouncer;

    localparam int D = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btns  = 4'b0000;
    wire  [1:0] num;
    wire        pressed;
    wire        press_pulse;
    wire        release_pulse;
    wire  [3:0] db_btns;

    always #5 clk = ~clk;

    btn_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .btns         (btns),
        .num          (num),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .db_btns      (db_btns)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a button's debounced level flips once the last D synchronised samples all disagree
    // with it; synchronised sample seen at edge n is the raw value taken at edge n-2.
    logic [3:0] m_win [0:D];
    logic [3:0] m_db      = 4'b0000;
    logic [3:0] m_nd;
    int         m_state   = 0;   // 0 idle, 1 held, 2 lockout
    logic [1:0] m_num     = 2'd0;
    logic       m_pressed = 1'b0;
    logic       m_pp      = 1'b0;
    logic       m_rp      = 1'b0;
    logic       m_flip;
    logic       m_found;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= D; k++) m_win[k] = 4'b0000;
            m_db = 4'b0000; m_state = 0; m_num = 2'd0;
            m_pressed = 1'b0; m_pp = 1'b0; m_rp = 1'b0;
        end else begin
            m_pp = 1'b0;
            m_rp = 1'b0;
            if (m_state == 0) begin
                if (m_db != 4'b0000) begin
                    m_found = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        if (m_db[i] && !m_found) begin
                            m_num = 2'(i);
                            m_found = 1'b1;
                        end
                    end
                    m_pressed = 1'b1; m_pp = 1'b1; m_state = 1;
                end
            end else if (m_state == 1) begin
                if (!m_db[m_num]) begin
                    m_pressed = 1'b0; m_rp = 1'b1;
                    m_state = (m_db == 4'b0000) ? 0 : 2;
                end
            end else if (m_db == 4'b0000) begin
                m_state = 0;
            end
            m_nd = m_db;
            for (int i = 0; i < 4; i++) begin
                m_flip = 1'b1;
                for (int k = 1; k <= D; k++) if (m_win[k][i] == m_db[i]) m_flip = 1'b0;
                if (m_flip) m_nd[i] = ~m_db[i];
            end
            m_db = m_nd;
            for (int k = D; k >= 1; k--) m_win[k] = m_win[k-1];
            m_win[0] = btns;
        end
    end

    always @(negedge clk) begin
        chk("db_btns", 32'(db_btns), 32'(m_db));
        chk("pressed", 32'(pressed), 32'(m_pressed));
        chk("press_pulse", 32'(press_pulse), 32'(m_pp));
        chk("release_pulse", 32'(release_pulse), 32'(m_rp));
        if (m_pressed) chk("num", 32'(num), 32'(m_num));
    end

    // Edges (first sample = 1) until the chosen pulse appears; 0 if it never does.
    task automatic edges_to(input bit rel, output int e);
        e = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if ((rel ? release_pulse : press_pulse) === 1'b1) begin
                e = k;
                break;
            end
        end
    endtask

    task automatic count_pp(input int cyc, output int n);
        n = 0;
        repeat (cyc) begin
            @(posedge clk); #1;
            if (press_pulse === 1'b1) n++;
        end
    endtask

    typedef struct {
        logic [3:0] b;
        int         cyc;
        int         pp;
        int         rp;
        logic [1:0] num;
        logic [3:0] db;
    } vec_t;

    vec_t       tbl [9];
    logic       bseq [6];
    int         e;
    int         n;
    int         npp;
    int         nrp;
    logic [1:0] lnum;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{4'b0010, 12, 1, 0, 2'd1, 4'b0010};
        tbl[1] = '{4'b0000, 12, 0, 1, 2'd0, 4'b0000};
        tbl[2] = '{4'b0011, 12, 1, 0, 2'd0, 4'b0011};
        tbl[3] = '{4'b0010, 12, 0, 1, 2'd0, 4'b0010};
        tbl[4] = '{4'b0000, 12, 0, 0, 2'd0, 4'b0000};
        tbl[5] = '{4'b1000,  3, 0, 0, 2'd0, 4'b0000};
        tbl[6] = '{4'b0000, 12, 0, 0, 2'd0, 4'b0000};
        tbl[7] = '{4'b1000,  4, 0, 0, 2'd0, 4'b0000};
        tbl[8] = '{4'b0000, 14, 1, 1, 2'd3, 4'b0000};
        bseq[0] = 1'b1; bseq[1] = 1'b0; bseq[2] = 1'b1;
        bseq[3] = 1'b1; bseq[4] = 1'b0; bseq[5] = 1'b1;

        // Reset with all buttons held
        #2 reset = 1'b0;
        btns = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {25'd0, num, pressed, press_pulse, release_pulse, db_btns}, 32'd0);
        reset = 1'b1;
        edges_to(1'b0, e);
        chk("rst_press_edges", e, 7);
        chk("rst_num", 32'(num), 0);
        chk("rst_pressed", 32'(pressed), 1);
        @(negedge clk); btns = 4'b0000;
        edges_to(1'b1, e);
        chk("rst_release_edges", e, 7);

        // Clean press of button 2
        repeat (4) @(negedge clk);
        btns = 4'b0100;
        edges_to(1'b0, e);
        chk("clean_press_edges", e, 7);
        chk("clean_num", 32'(num), 2);
        count_pp(13, n);
        chk("clean_single_press", n, 0);
        chk("clean_still_pressed", 32'(pressed), 1);
        @(negedge clk); btns = 4'b0000;
        edges_to(1'b1, e);
        chk("clean_release_edges", e, 7);

        // Bounce on button 1
        repeat (6) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            btns = {2'b00, bseq[k], 1'b0};
            @(negedge clk);
        end
        btns = {2'b00, bseq[5], 1'b0};
        edges_to(1'b0, e);
        chk("bounce_press_edges", e, 7);
        chk("bounce_num", 32'(num), 1);
        @(negedge clk); btns = 4'b0000;
        repeat (10) @(posedge clk);

        // Chord 1010, then lockout of button 3
        @(negedge clk); btns = 4'b1010;
        edges_to(1'b0, e);
        chk("chord_press_edges", e, 7);
        chk("chord_num", 32'(num), 1);
        @(negedge clk); btns = 4'b1000;
        edges_to(1'b1, e);
        chk("chord_release_edges", e, 7);
        count_pp(15, n);
        chk("chord_lockout_no_press", n, 0);
        @(negedge clk); btns = 4'b0000;
        repeat (10) @(posedge clk);
        @(negedge clk); btns = 4'b1000;
        edges_to(1'b0, e);
        chk("repress_edges", e, 7);
        chk("repress_num", 32'(num), 3);
        @(negedge clk); btns = 4'b0000;
        repeat (10) @(posedge clk);

        // Late second button
        @(negedge clk); btns = 4'b0001;
        edges_to(1'b0, e);
        chk("late_press_edges", e, 7);
        @(negedge clk); btns = 4'b0101;
        count_pp(12, n);
        chk("late_no_extra_press", n, 0);
        chk("late_num", 32'(num), 0);
        chk("late_db", 32'(db_btns), 32'h5);
        @(negedge clk); btns = 4'b0000;
        repeat (10) @(posedge clk);

        // Reset mid-press
        @(negedge clk); btns = 4'b0100;
        edges_to(1'b0, e);
        chk("midrst_press_edges", e, 7);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("midrst_pressed", 32'(pressed), 0);
        chk("midrst_db", 32'(db_btns), 0);
        chk("midrst_no_release", 32'(release_pulse), 0);
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        edges_to(1'b0, e);
        chk("midrst_repress_edges", e, 7);
        chk("midrst_num", 32'(num), 2);
        @(negedge clk); btns = 4'b0000;
        repeat (12) @(posedge clk);

        // Vector table
        foreach (tbl[r]) begin
            @(negedge clk);
            btns = tbl[r].b;
            npp = 0; nrp = 0; lnum = 2'd0;
            repeat (tbl[r].cyc) begin
                @(posedge clk); #1;
                if (press_pulse === 1'b1) begin npp++; lnum = num; end
                if (release_pulse === 1'b1) nrp++;
            end
            chk($sformatf("row%0d_press", r), npp, tbl[r].pp);
            chk($sformatf("row%0d_release", r), nrp, tbl[r].rp);
            chk($sformatf("row%0d_db", r), 32'(db_btns), 32'(tbl[r].db));
            if (tbl[r].pp > 0) chk($sformatf("row%0d_num", r), 32'(lnum), 32'(tbl[r].num));
        end

        // Random stimulus against the reference model
        for (int it = 0; it < 250; it++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) btns = 4'b0001 << $urandom_range(0, 3);
            else if ($urandom_range(0, 3) == 0) btns = 4'b0000;
            else btns = 4'($urandom);
            repeat ($urandom_range(0, 11)) @(negedge clk);
        end
        btns = 4'b0000;
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_debouncer.md
Name: btn_debouncer

Overview:
- Upstream conditioning stage for the Simon player path; sits between the raw board pushbuttons and the button-to-number decode and Simon game logic.
- Synchronises and debounces the four raw buttons.
- Arbitrates simultaneous presses down to one accepted button.
- Emits a clean held level plus one-cycle press/release events. Simon therefore sees exactly one press per physical push, with no bounce or chording artefacts.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples required before a button's debounced state changes. This is 10 ms at 50 MHz. Minimum 2.
- CNT_W, 20: width of each per-button stability counter. Must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock, all flops rising edge
- reset  input  1  asynchronous, active-low reset
- btns  input  4  raw pushbuttons, asynchronous, active-high, btns[i] = colour i
- num  output  2  index of the accepted button; valid while pressed=1
- pressed  output  1  level: accepted button is debounced-held
- press_pulse  output  1  one-cycle strobe on acceptance of a new press
- release_pulse  output  1  one-cycle strobe when the accepted button debounces released
- db_btns  output  4  debounced state of all four buttons, for display/debug

Behaviour:
- Reset (reset=0, asynchronous): the following all clear to 0 and the FSM goes to IDLE.
  - synchroniser flops and counters
  - db_btns, num=2'b00, pressed, press_pulse, release_pulse
- Synchroniser: a 2-flop chain per button. s[i] is the second flop.
- Debounce, per button i, evaluated every cycle:
  - s[i]==db[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1: db[i] <= s[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Any glitch shorter than DEBOUNCE_CYCLES samples restarts the count and never reaches db.
- Latency: a raw change first sampled at edge 1 and held stable updates db at edge DEBOUNCE_CYCLES+2. The FSM outputs (pressed, press_pulse, release_pulse, num) update at edge DEBOUNCE_CYCLES+3.
- Arbitration FSM, registered outputs, driven by db:
  - IDLE: pressed=0.
    - If db!=0, latch num = lowest set index of db, set pressed=1, pulse press_pulse, go to HELD.
  - HELD: pressed=1, num frozen. Other buttons debouncing down are ignored.
    - When db[num] falls: pressed=0, pulse release_pulse.
    - Then go to IDLE if db==0 at that point, else go to LOCKOUT.
  - LOCKOUT: pressed=0. Wait until db==0, then go to IDLE.
    - A button still held from a chord never produces a press; it must be released and re-pressed.
- Simultaneous debounce of several buttons in the same cycle while in IDLE: the lowest index wins.
- press_pulse and release_pulse:
  - are never high in the same cycle;
  - are at most one cycle wide;
  - at least one cycle separates a release_pulse from the next press_pulse (the FSM passes through IDLE).
- num holds its last value when pressed=0 and is undefined-for-use there. Consumers gate it with pressed.
- Reset asserted mid-press: everything clears immediately.
  - After reset deasserts with a button still physically held, that button needs DEBOUNCE_CYCLES stable samples and then produces a normal press.
- Counter widths: cnt is CNT_W bits. The compare is exact equality, so there is no wrap because cnt never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared game package holds:
  - NUM_BTNS=4
  - the colour index constants (0..3) shared with the number-to-LED and number-to-frequency blocks
  - the FSM state encoding constants IDLE/HELD/LOCKOUT
- One natural sub-module: btn_debounce_bit. It holds the 2-flop synchroniser plus one stability counter, with ports clk, reset, raw, db. It is instantiated four times.
- The arbitration FSM stays in btn_debouncer.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=3.
- Reset: hold reset=0 with btns=4'b1111, release reset → all outputs 0. Press acceptance happens 7 edges after the first post-reset sample: press_pulse once, num=0, pressed=1.
- Clean press: btns=4'b0100 held 20 cycles, then 0 → press_pulse exactly 7 edges after the first sample, num=2. pressed stays high until release. release_pulse fires 7 edges after the release is first sampled. Exactly one of each pulse.
- Bounce: btns[1] toggles 1,0,1,1,0,1 at 1-cycle spacing, then is steady 1 → no pulse during the bouncing. A single press_pulse with num=1 appears 7 edges after the final rising sample.
- Chord: btns goes 0000→1010 in the same cycle → num=1 and one press_pulse. Then drop bit 1 while bit 3 stays held → release_pulse, FSM goes to LOCKOUT, no press for button 3. Release all, then press btn 3 → press_pulse with num=3.
- Late second button: hold btn 0, then after acceptance also hold btn 2 → num stays 0, no additional press_pulse, db_btns=4'b0101.
- Reset mid-press: in HELD with num=2, pulse reset low for 1 cycle → pressed=0 and db_btns=0 asynchronously. No release_pulse is generated. The still-held btn 2 produces press_pulse 7 edges after reset deasserts.
